// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS-subset control FSM; jal decode enabled by MULTICYCLE_CTRL_JAL_EN
module multicycle_ctrl #(
    parameter int ALUCTR_W = 4,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          OP,
    input  logic [5:0]          func,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                IorD,
    output logic                MemRd,
    output logic                MemWr,
    output logic                IRWr,
    output logic                PCWr,
    output logic [1:0]          PCsrc,
    output logic [1:0]          RegDst,
    output logic                ALUsrcA,
    output logic [1:0]          ALUsrcB,
    output logic [ALUCTR_W-1:0] ALUctr,
    output logic                ExtOp,
    output logic                MemtoReg,
    output logic                RegWr,
    output logic                retire,
    output logic                illegal,
    output logic [3:0]          state,
    output logic [CNT_W-1:0]    instret
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MULTICYCLE_CTRL_JAL_EN
    localparam logic [5:0] OP_JAL   = 6'b000011;
`endif

    localparam logic [3:0] ALU_ADDU = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_OR   = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_SUBU = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_LUI  = 4'b1000;

    function automatic logic func_ok(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100001, 6'b100010, 6'b100011,
            6'b100100, 6'b100101, 6'b101010, 6'b101011: func_ok = 1'b1;
            default:                                    func_ok = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] func_alu(input logic [5:0] f);
        case (f)
            6'b100000: func_alu = ALU_ADD;
            6'b100001: func_alu = ALU_ADDU;
            6'b100010: func_alu = ALU_SUB;
            6'b100011: func_alu = ALU_SUBU;
            6'b100100: func_alu = ALU_AND;
            6'b100101: func_alu = ALU_OR;
            6'b101010: func_alu = ALU_SLT;
            6'b101011: func_alu = ALU_SLTU;
            default:   func_alu = ALU_ADDU;
        endcase
    endfunction

    function automatic logic [3:0] ialu_alu(input logic [5:0] o);
        case (o)
            OP_ORI:  ialu_alu = ALU_OR;
            OP_LUI:  ialu_alu = ALU_LUI;
            default: ialu_alu = ALU_ADDU;
        endcase
    endfunction

    function automatic logic op_ok(input logic [5:0] o, input logic [5:0] f);
        case (o)
            OP_R:                              op_ok = func_ok(f);
            OP_J, OP_BEQ, OP_BNE, OP_ADDIU,
            OP_ORI, OP_LUI, OP_LW, OP_SW:      op_ok = 1'b1;
`ifdef MULTICYCLE_CTRL_JAL_EN
            OP_JAL:                            op_ok = 1'b1;
`endif
            default:                           op_ok = 1'b0;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [5:0] op_q, func_q;
    logic [3:0] aluc;
    logic       is_r, is_ialu, is_lw, is_sw, is_br;

    assign is_r    = (op_q == OP_R);
    assign is_ialu = (op_q == OP_ORI) || (op_q == OP_ADDIU) || (op_q == OP_LUI);
    assign is_lw   = (op_q == OP_LW);
    assign is_sw   = (op_q == OP_SW);
    assign is_br   = (op_q == OP_BEQ) || (op_q == OP_BNE);

    always_comb begin
        state_d  = state_q;
        IorD     = 1'b0;
        MemRd    = 1'b0;
        MemWr    = 1'b0;
        IRWr     = 1'b0;
        PCWr     = 1'b0;
        PCsrc    = 2'b00;
        RegDst   = 2'b00;
        ALUsrcA  = 1'b0;
        ALUsrcB  = 2'b00;
        aluc     = ALU_ADDU;
        ExtOp    = 1'b0;
        MemtoReg = 1'b0;
        RegWr    = 1'b0;
        retire   = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            FETCH: begin
                MemRd   = 1'b1;
                ALUsrcB = 2'b01;
                // Write strobes stay low while reset holds the FSM here.
                if (mem_ready && rst_n) begin
                    IRWr    = 1'b1;
                    PCWr    = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                ALUsrcB = 2'b11;
                ExtOp   = 1'b1;
                state_d = op_ok(OP, func) ? EXEC : TRAP;
            end
            EXEC: begin
                state_d = FETCH;
                if (is_r) begin
                    ALUsrcA = 1'b1;
                    aluc    = func_alu(func_q);
                    state_d = WB;
                end else if (is_ialu) begin
                    ALUsrcA = 1'b1;
                    ALUsrcB = 2'b10;
                    ExtOp   = (op_q == OP_ADDIU);
                    aluc    = ialu_alu(op_q);
                    state_d = WB;
                end else if (is_lw || is_sw) begin
                    ALUsrcA = 1'b1;
                    ALUsrcB = 2'b10;
                    ExtOp   = 1'b1;
                    state_d = MEM;
                end else if (is_br) begin
                    ALUsrcA = 1'b1;
                    aluc    = ALU_SUBU;
                    PCsrc   = 2'b01;
                    PCWr    = (op_q == OP_BEQ) ? zero : !zero;
                    retire  = 1'b1;
                end else if (op_q == OP_J) begin
                    PCsrc   = 2'b10;
                    PCWr    = 1'b1;
                    retire  = 1'b1;
                end
`ifdef MULTICYCLE_CTRL_JAL_EN
                else if (op_q == OP_JAL) begin
                    PCsrc   = 2'b10;
                    PCWr    = 1'b1;
                    RegWr   = 1'b1;
                    RegDst  = 2'b10;
                    retire  = 1'b1;
                end
`endif
            end
            MEM: begin
                IorD  = 1'b1;
                MemRd = is_lw;
                MemWr = is_sw;
                if (mem_ready) begin
                    if (is_lw) begin
                        state_d = WB;
                    end else begin
                        retire  = is_sw;
                        state_d = FETCH;
                    end
                end
            end
            WB: begin
                RegWr    = 1'b1;
                RegDst   = is_r ? 2'b01 : 2'b00;
                MemtoReg = is_lw;
                retire   = 1'b1;
                // Keep the ALU op visible through write-back for ALU-class instructions.
                if (is_r)         aluc = func_alu(func_q);
                else if (is_ialu) aluc = ialu_alu(op_q);
                state_d  = FETCH;
            end
            TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_comb begin
        ALUctr      = '0;
        ALUctr[3:0] = aluc;
    end

    assign state = {1'b0, state_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            op_q    <= '0;
            func_q  <= '0;
            instret <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                op_q   <= OP;
                func_q <= func;
            end
            if (retire) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed and random instruction bench for multicycle_ctrl
module tb_multicycle_ctrl;

    localparam int AW = 5;
    localparam int CW = 4;

    localparam logic [5:0] R     = 6'b000000;
    localparam logic [5:0] J     = 6'b000010;
    localparam logic [5:0] JAL   = 6'b000011;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] BNE   = 6'b000101;
    localparam logic [5:0] ADDIU = 6'b001001;
    localparam logic [5:0] ORI   = 6'b001101;
    localparam logic [5:0] LUI   = 6'b001111;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [5:0]    OP, func;
    logic          zero, mem_ready;
    logic          IorD, MemRd, MemWr, IRWr, PCWr;
    logic [1:0]    PCsrc, RegDst, ALUsrcB;
    logic          ALUsrcA, ExtOp, MemtoReg, RegWr, retire, illegal;
    logic [AW-1:0] ALUctr;
    logic [3:0]    state;
    logic [CW-1:0] instret;

    multicycle_ctrl #(.ALUCTR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .OP(OP), .func(func), .zero(zero), .mem_ready(mem_ready),
        .IorD(IorD), .MemRd(MemRd), .MemWr(MemWr), .IRWr(IRWr), .PCWr(PCWr), .PCsrc(PCsrc),
        .RegDst(RegDst), .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .ALUctr(ALUctr), .ExtOp(ExtOp),
        .MemtoReg(MemtoReg), .RegWr(RegWr), .retire(retire), .illegal(illegal),
        .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]    st;
        logic          iord, memrd, memwr, irwr, pcwr;
        logic [1:0]    pcsrc, regdst;
        logic          alusrca;
        logic [1:0]    alusrcb;
        logic [AW-1:0] aluctr;
        logic          extop, memtoreg, regwr, retire, illegal;
    } vec_t;

    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] exp_cnt = '0;
    logic          zv = 1'b0;
    logic [5:0]    rf [8] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h2b};

    function automatic logic legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == R) return fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h2b};
`ifdef MULTICYCLE_CTRL_JAL_EN
        if (op == JAL) return 1'b1;
`endif
        return op inside {J, BEQ, BNE, ADDIU, ORI, LUI, LW, SW};
    endfunction

    function automatic logic is_alu(input logic [5:0] op);
        return op inside {R, ORI, ADDIU, LUI};
    endfunction

    // ALU operation named by the instruction; addiu and address arithmetic are plain addu.
    function automatic logic [3:0] alu_of(input logic [5:0] op, input logic [5:0] fn);
        if (op == R) begin
            case (fn)
                6'h20:   return 4'd1;
                6'h22:   return 4'd5;
                6'h23:   return 4'd4;
                6'h24:   return 4'd3;
                6'h25:   return 4'd2;
                6'h2a:   return 4'd7;
                6'h2b:   return 4'd6;
                default: return 4'd0;
            endcase
        end
        if (op == ORI) return 4'd2;
        if (op == LUI) return 4'd8;
        return 4'd0;
    endfunction

    function automatic vec_t v_fetch(input logic rdy);
        vec_t v;
        v = '0;
        v.memrd = 1'b1; v.alusrcb = 2'b01;
        v.irwr = rdy; v.pcwr = rdy;
        return v;
    endfunction

    function automatic vec_t v_decode();
        vec_t v;
        v = '0;
        v.st = 4'd1; v.alusrcb = 2'b11; v.extop = 1'b1;
        return v;
    endfunction

    function automatic vec_t v_trap();
        vec_t v;
        v = '0;
        v.st = 4'd5; v.illegal = 1'b1;
        return v;
    endfunction

    function automatic vec_t v_exec(input logic [5:0] op, input logic [5:0] fn, input logic z);
        vec_t v;
        v = '0;
        v.st = 4'd2;
        if (op == R) begin
            v.alusrca = 1'b1; v.aluctr = alu_of(op, fn);
        end else if (op inside {ORI, ADDIU, LUI}) begin
            v.alusrca = 1'b1; v.alusrcb = 2'b10; v.extop = (op == ADDIU); v.aluctr = alu_of(op, fn);
        end else if (op inside {LW, SW}) begin
            v.alusrca = 1'b1; v.alusrcb = 2'b10; v.extop = 1'b1;
        end else if (op inside {BEQ, BNE}) begin
            v.alusrca = 1'b1; v.aluctr = 4'b0100; v.pcsrc = 2'b01; v.retire = 1'b1;
            v.pcwr = (op == BEQ) ? z : !z;
        end else if (op == J) begin
            v.pcsrc = 2'b10; v.pcwr = 1'b1; v.retire = 1'b1;
        end else if (op == JAL) begin
            v.pcsrc = 2'b10; v.pcwr = 1'b1; v.regwr = 1'b1; v.regdst = 2'b10; v.retire = 1'b1;
        end
        return v;
    endfunction

    function automatic vec_t v_mem(input logic [5:0] op, input logic rdy);
        vec_t v;
        v = '0;
        v.st = 4'd3; v.iord = 1'b1;
        v.memrd = (op == LW); v.memwr = (op == SW);
        v.retire = rdy && (op == SW);
        return v;
    endfunction

    function automatic vec_t v_wb(input logic [5:0] op, input logic [5:0] fn);
        vec_t v;
        v = '0;
        v.st = 4'd4; v.regwr = 1'b1; v.retire = 1'b1;
        v.regdst = (op == R) ? 2'b01 : 2'b00;
        v.memtoreg = (op == LW);
        v.aluctr = is_alu(op) ? alu_of(op, fn) : 4'd0;
        return v;
    endfunction

    function automatic vec_t obs();
        vec_t v;
        v.st = state; v.iord = IorD; v.memrd = MemRd; v.memwr = MemWr; v.irwr = IRWr;
        v.pcwr = PCWr; v.pcsrc = PCsrc; v.regdst = RegDst; v.alusrca = ALUsrcA;
        v.alusrcb = ALUsrcB; v.aluctr = ALUctr; v.extop = ExtOp; v.memtoreg = MemtoReg;
        v.regwr = RegWr; v.retire = retire; v.illegal = illegal;
        return v;
    endfunction

    task automatic cmp_vec(input vec_t e, input string tag);
        checks++;
        assert (obs() === e) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs(), e);
        end
    endtask

    task automatic cmp_cnt(input string tag);
        checks++;
        assert (instret === exp_cnt) else begin
            errors++;
            $error("FAIL %s_instret observed %0d expected %0d", tag, instret, exp_cnt);
        end
    endtask

    task automatic cyc(input vec_t e, input logic mr, input string tag);
        @(negedge clk);
        mem_ready = mr;
        zero = zv;
        #1;
        cmp_vec(e, tag);
        cmp_cnt(tag);
        if (e.retire) exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic assert_reset(input string tag);
        #1 rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        exp_cnt = '0;
        cmp_vec(v_fetch(1'b0), tag);
        cmp_cnt(tag);
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        assert_reset(tag);
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fw, input int mw, input logic z);
        OP = op;
        func = fn;
        zv = z;
        for (int i = 0; i < fw; i++) cyc(v_fetch(1'b0), 1'b0, "fetch_wait");
        cyc(v_fetch(1'b1), 1'b1, "fetch");
        cyc(v_decode(), 1'($urandom_range(0, 1)), "decode");
        if (!legal(op, fn)) begin
            for (int i = 0; i < 10; i++) cyc(v_trap(), 1'($urandom_range(0, 1)), "trap");
            return;
        end
        cyc(v_exec(op, fn, z), 1'($urandom_range(0, 1)), "exec");
        if (op inside {LW, SW}) begin
            for (int i = 0; i < mw; i++) cyc(v_mem(op, 1'b0), 1'b0, "mem_wait");
            cyc(v_mem(op, 1'b1), 1'b1, "mem");
        end
        if (is_alu(op) || op == LW) cyc(v_wb(op, fn), 1'($urandom_range(0, 1)), "wb");
    endtask

    initial begin
        logic [5:0] rop, rfn;
        rst_n = 1'b0;
        OP = '0;
        func = '0;
        zero = 1'b0;
        mem_ready = 1'b0;
        do_reset("reset");

        run_instr(R, 6'h20, 0, 0, 1'b0);
        run_instr(LW, 6'h00, 0, 3, 1'b0);
        run_instr(BEQ, 6'h00, 0, 0, 1'b1);
        run_instr(BEQ, 6'h00, 0, 0, 1'b0);
        run_instr(BNE, 6'h00, 0, 0, 1'b1);
        run_instr(BNE, 6'h00, 0, 0, 1'b0);
        run_instr(J, 6'h00, 2, 0, 1'b0);
        run_instr(SW, 6'h00, 1, 2, 1'b0);
        run_instr(ORI, 6'h00, 0, 0, 1'b0);
        run_instr(ADDIU, 6'h00, 0, 0, 1'b0);
        run_instr(LUI, 6'h00, 0, 0, 1'b0);
        run_instr(JAL, 6'h00, 0, 0, 1'b0);
        if (!legal(JAL, 6'h00)) do_reset("jal_trap_reset");
        run_instr(R, 6'h3f, 0, 0, 1'b0);
        do_reset("bad_func_reset");

        for (int i = 0; i < 60; i++) begin
            int k;
            k = int'($urandom_range(0, 17));
            rfn = 6'($urandom);
            case (k)
                8:       rop = LW;
                9:       rop = SW;
                10:      rop = BEQ;
                11:      rop = BNE;
                12:      rop = J;
                13:      rop = ORI;
                14:      rop = ADDIU;
                15:      rop = LUI;
                16:      rop = JAL;
                17:      rop = 6'($urandom);
                default: begin rop = R; rfn = rf[k]; end
            endcase
            run_instr(rop, rfn, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)));
            if (!legal(rop, rfn)) do_reset("rand_trap_reset");
        end

        run_instr(6'b111111, 6'h00, 0, 0, 1'b0);
        do_reset("trap_reset");

        OP = SW;
        func = 6'h00;
        zv = 1'b0;
        cyc(v_fetch(1'b1), 1'b1, "abort_fetch");
        cyc(v_decode(), 1'b1, "abort_decode");
        cyc(v_exec(SW, 6'h00, 1'b0), 1'b1, "abort_exec");
        cyc(v_mem(SW, 1'b0), 1'b0, "abort_mem0");
        cyc(v_mem(SW, 1'b0), 1'b0, "abort_mem1");
        assert_reset("abort_reset");
        cyc(v_fetch(1'b0), 1'b0, "abort_idle");
        run_instr(R, 6'h21, 0, 0, 1'b0);

        @(negedge clk);
        #1;
        cmp_cnt("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter ALUCTR_W, default 4, meaning ALU control width; SHALL be >= 4, upper bits zero-filled.
REQ-002 Parameter CNT_W, default 32, meaning retired-instruction counter width.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 OP  input  6  opcode field of the instruction register.
REQ-006 func  input  6  function field of the instruction register (R-type only).
REQ-007 zero  input  1  ALU zero flag, sampled in EXEC.
REQ-008 mem_ready  input  1  memory handshake; access completes on the cycle it is high.
REQ-009 Outputs, each 1 bit unless stated: IorD, MemRd, MemWr, IRWr, PCWr, PCsrc[1:0], RegDst[1:0], ALUsrcA, ALUsrcB[1:0], ALUctr[ALUCTR_W-1:0], ExtOp, MemtoReg, RegWr, retire, illegal, state[3:0], instret[CNT_W-1:0].

Function
REQ-010 FSM states SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; state output SHALL show the current encoding.
REQ-011 FETCH: MemRd=1, IorD=0, ALUsrcA=0, ALUsrcB=01, ALUctr=addu; stay while mem_ready=0; on mem_ready=1 assert IRWr=1, PCWr=1, PCsrc=00 for that cycle and go to DECODE.
REQ-012 DECODE: latch OP/func into op_q/func_q; ALUsrcA=0, ALUsrcB=11, ExtOp=1 (branch target); unsupported OP, or OP=0 with unsupported func, SHALL go to TRAP, else EXEC.
REQ-013 Supported: R-type add/addu/sub/subu/and/or/slt/sltu, lw, sw, beq, bne, j, ori, addiu, lui.
REQ-014 ALUctr encoding: addu 0000, add 0001, or 0010, and 0011, subu 0100, sub 0101, sltu 0110, slt 0111, lui 1000.
REQ-015 EXEC, R-type: ALUsrcA=1, ALUsrcB=00, ALUctr from func_q; next WB.
REQ-016 EXEC, ori/addiu/lui: ALUsrcA=1, ALUsrcB=10, ExtOp=1 for addiu only; next WB.
REQ-017 EXEC, lw/sw: ALUsrcA=1, ALUsrcB=10, ExtOp=1, ALUctr=addu; next MEM.
REQ-018 EXEC, beq/bne: ALUsrcA=1, ALUsrcB=00, ALUctr=subu, PCsrc=01; PCWr=1 iff (beq and zero) or (bne and !zero); retire=1; next FETCH.
REQ-019 EXEC, j: PCsrc=10, PCWr=1, retire=1; next FETCH.
REQ-020 MEM: IorD=1, MemRd=1 for lw, MemWr=1 for sw; stay while mem_ready=0; on mem_ready=1 lw goes to WB, sw asserts retire=1 and goes to FETCH.
REQ-021 WB: RegWr=1 for one cycle; RegDst=01 for R-type, 00 otherwise; MemtoReg=1 for lw only; retire=1; next FETCH.
REQ-022 Latency with mem_ready tied high: R/I-ALU 4 cycles, lw 5, sw 4, beq/bne/j 3.
REQ-023 All outputs not explicitly driven in a state SHALL be 0; MemRd and MemWr SHALL never be high together.
REQ-024 TRAP: illegal=1, all other control outputs 0, state held until reset.
REQ-025 instret SHALL increment by 1 on every cycle retire=1, wrapping from all-ones to 0.
REQ-026 mem_ready outside FETCH/MEM SHALL be ignored.

Reset
REQ-027 rst_n low SHALL immediately force state=FETCH, op_q=func_q=0, illegal=0, instret=0, all outputs to FETCH-state values with IRWr=PCWr=0.
REQ-028 Reset asserted mid-instruction (including during a MEM wait) SHALL abandon it with no retire pulse and no RegWr/MemWr afterwards.
REQ-029 After rst_n rises, the first rising edge SHALL evaluate FETCH normally.

Configuration
REQ-030 Macro MULTICYCLE_CTRL_JAL_EN: when defined, OP=000011 (jal) SHALL be decoded; EXEC asserts PCsrc=10, PCWr=1, RegWr=1, RegDst=10 (register 31), MemtoReg=0, retire=1 in one cycle; next FETCH.
REQ-031 Without MULTICYCLE_CTRL_JAL_EN, OP=000011 SHALL go to TRAP and RegDst=10 SHALL never occur.

Verification
REQ-032 Reset, mem_ready=1, OP=0 func=100000 -> states 0,1,2,4; WB: RegWr=1, RegDst=01, ALUctr=0001; retire once; instret=1.
REQ-033 lw (OP=100011), mem_ready low 3 cycles in MEM -> MEM held 4 cycles, MemRd=1 IorD=1 throughout, then WB with MemtoReg=1; total 8 cycles.
REQ-034 beq with zero=1 then zero=0 -> PCWr=1 PCsrc=01 in EXEC first time, PCWr=0 second; bne inverts both.
REQ-035 OP=111111 -> TRAP after DECODE, illegal=1 held for 10 cycles, no RegWr/MemWr; rst_n pulse low -> illegal=0, state=0.
REQ-036 rst_n low during sw MEM wait -> state=0 asynchronously, MemWr=0, instret unchanged at 0.
REQ-037 jal with and without MULTICYCLE_CTRL_JAL_EN -> RegWr=1 RegDst=10 PCWr=1 in EXEC, vs TRAP with illegal=1.
